core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Multi-cycle control FSM for the single-issue core. It sequences each instruction through fetch, decode, execute, memory and writeback. It handshakes with instruction and data memory and generates the register-file, IR and PC write strobes. Decoded control fields come from the instruction decoder, which is fed from the IR this block loads. The block also keeps a retired-instruction counter.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
i_clk  in  1  core clock; single clock domain
i_rst  in  1  reset, synchronous, active-high
i_imem_ready  in  1  instruction memory accepts the request and returns data this cycle
i_dmem_ready  in  1  data memory completes the access this cycle
i_is_load  in  1  decoded: load instruction
i_is_store  in  1  decoded: store instruction
i_wb_we  in  1  decoded: instruction writes rd
i_jump  in  1  decoded: jal/jalr
i_cond_br  in  1  decoded: conditional branch
i_br_taken  in  1  branch comparator result from ALU
i_env  in  1  decoded: ENV opcode (ecall/ebreak)
o_imem_req  out  1  instruction fetch request
o_ir_we  out  1  load fetched word into IR
o_dmem_req  out  1  data memory request
o_dmem_we  out  1  data memory write (valid only with o_dmem_req)
o_rf_we  out  1  register-file write strobe
o_pc_we  out  1  PC update strobe
o_pc_sel  out  1  0 = PC+4, 1 = ALU target
o_halted  out  1  core halted on ENV
o_state  out  3  current state encoding, for debug
o_instret  out  RETIRE_W  retired-instruction count

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States (3-bit): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 are unused; if reached, go to FETCH on the next edge with all strobes 0.
- Reset: at the i_rst edge, state := FETCH and o_instret := 0. While i_rst=1, all strobes (imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we) are forced 0, o_pc_sel=0, and o_halted reflects the registered state.
- Outputs are combinational from state plus the listed inputs. There are no registered output delays.
- FETCH: o_imem_req=1, held until i_imem_ready. In the cycle i_imem_ready=1, o_ir_we=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle; register file is read.
  - i_env=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC: one cycle, ALU evaluates.
  - i_is_load or i_is_store -> MEM.
  - Otherwise -> WB.
- MEM: o_dmem_req=1 and o_dmem_we=i_is_store, held constant until i_dmem_ready. On i_dmem_ready -> WB.
- WB: one cycle; then -> FETCH.
  - o_rf_we=i_wb_we. Stores and branches have i_wb_we=0 from the decoder; the sequencer does not re-qualify it.
  - o_pc_we=1.
  - o_pc_sel = i_jump | (i_cond_br & i_br_taken).
  - o_instret increments by 1 at the edge leaving WB.
- HALT: sticky until i_rst. o_halted=1, all strobes 0, o_instret frozen. The ENV instruction is not counted as retired.
- Minimum latency: ALU/branch/jump instruction with zero-wait imem = 4 cycles (FETCH, DECODE, EXEC, WB). Load/store with zero-wait memories = 5 cycles.
- Ready inputs are ignored outside their owning state: i_imem_ready outside FETCH, i_dmem_ready outside MEM.
- Decoded inputs must be stable from DECODE through WB; the IR is written only in FETCH.
- Reset mid-MEM or mid-FETCH: the request deasserts in the reset cycle, and no rf/pc write occurs. Memories must tolerate an abandoned request.
- o_instret wraps from 2^RETIRE_W-1 to 0 with no flag.

Decomposition:
- Shared package `types`: enum `seq_state_t` (3-bit, the codes above), alongside the existing `alu_op_t`.
- No sub-module. The counter and FSM are inline, in one always_ff block for state and counter and one always_comb block for next-state and outputs.

Test Plan:
- ADDI, imem_ready=1 always: state trace 0,1,2,4,0. o_ir_we high in cycle 0, o_rf_we and o_pc_we high in cycle 3 with o_pc_sel=0; o_instret 0->1.
- imem_ready low 3 cycles then high: o_imem_req high 4 consecutive cycles, o_ir_we high only in the 4th cycle; DECODE follows.
- SW (i_is_store=1, i_wb_we=0), dmem_ready low 2 cycles: o_dmem_req=o_dmem_we=1 for 3 cycles, then WB with o_rf_we=0, o_pc_we=1, o_pc_sel=0.
- BEQ with i_br_taken=1 -> WB has o_pc_sel=1, o_rf_we=0. With i_br_taken=0 -> o_pc_sel=0. JAL with i_br_taken=0 -> o_pc_sel=1, o_rf_we=1.
- ECALL (i_env=1): state 0,1,7. o_halted=1 and no o_imem_req for 20 cycles; o_instret unchanged. Then i_rst for 1 cycle -> state 0, o_instret=0.
- Assert i_rst during MEM: o_dmem_req=0 in that cycle, no o_rf_we/o_pc_we, state=FETCH next cycle. With RETIRE_W=4, 16 retired ALU ops give o_instret=0.

Source files
------------

// File: rtl/types.sv
// rtl/types.sv - shared core types: ALU operations and sequencer state codes
package types;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Codes 5 and 6 are deliberately unassigned; the sequencer recovers to FETCH from them.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } seq_state_t;

endpackage

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/mem/writeback control FSM
// with retired-instruction counter; all strobes are combinational from state and inputs.
module core_sequencer
  import types::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_imem_ready,
  input  logic                i_dmem_ready,
  input  logic                i_is_load,
  input  logic                i_is_store,
  input  logic                i_wb_we,
  input  logic                i_jump,
  input  logic                i_cond_br,
  input  logic                i_br_taken,
  input  logic                i_env,
  output logic                o_imem_req,
  output logic                o_ir_we,
  output logic                o_dmem_req,
  output logic                o_dmem_we,
  output logic                o_rf_we,
  output logic                o_pc_we,
  output logic                o_pc_sel,
  output logic                o_halted,
  output logic [2:0]          o_state,
  output logic [RETIRE_W-1:0] o_instret
);

  seq_state_t state;
  seq_state_t state_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_FETCH;
      o_instret <= '0;
    end else begin
      state <= state_next;
      if (state == S_WB)
        o_instret <= o_instret + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    o_imem_req = 1'b0;
    o_ir_we    = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 1'b0;
    o_halted   = (state == S_HALT);
    o_state    = state;

    case (state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_we    = i_imem_ready;
        if (i_imem_ready)
          state_next = S_DECODE;
      end
      S_DECODE: state_next = i_env ? S_HALT : S_EXEC;
      S_EXEC:   state_next = (i_is_load || i_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_is_store;
        if (i_dmem_ready)
          state_next = S_WB;
      end
      S_WB: begin
        o_rf_we    = i_wb_we;
        o_pc_we    = 1'b1;
        o_pc_sel   = i_jump | (i_cond_br & i_br_taken);
        state_next = S_FETCH;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase

    // Reset masks every strobe so abandoned memory requests drop in the reset cycle itself.
    if (i_rst) begin
      o_imem_req = 1'b0;
      o_ir_we    = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_rf_we    = 1'b0;
      o_pc_we    = 1'b0;
      o_pc_sel   = 1'b0;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - scoreboard bench: driver queues per-cycle expected outputs
// from an instruction-level model, a negedge monitor pops and compares.
module tb_core_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_ready, dmem_ready;
  logic       is_load, is_store, wb_we, jump, cond_br, br_taken, env;
  logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, halted;
  logic [2:0] state;
  logic [3:0] instret;

  core_sequencer #(.RETIRE_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_imem_ready(imem_ready), .i_dmem_ready(dmem_ready),
    .i_is_load(is_load), .i_is_store(is_store), .i_wb_we(wb_we),
    .i_jump(jump), .i_cond_br(cond_br), .i_br_taken(br_taken), .i_env(env),
    .o_imem_req(imem_req), .o_ir_we(ir_we), .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we), .o_rf_we(rf_we), .o_pc_we(pc_we), .o_pc_sel(pc_sel),
    .o_halted(halted), .o_state(state), .o_instret(instret)
  );

  always #5 clk = ~clk;

  // {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, halted, instret}
  typedef logic [14:0] obs_t;
  obs_t exp_q[$];
  int   model_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_ENV = 5;

  function automatic obs_t mk(input logic [2:0] st, input logic [7:0] f);
    return {st, f, 4'(model_cnt)};
  endfunction

  task automatic step(input obs_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_dec();
    is_load  = 1'($urandom);
    is_store = 1'($urandom);
    wb_we    = 1'($urandom);
    jump     = 1'($urandom);
    cond_br  = 1'($urandom);
    br_taken = 1'($urandom);
    env      = 1'($urandom);
  endtask

  task automatic run_instr(input int kind, input int iw, input int dw,
                           input bit rst_in_mem, input bit taken);
    logic ld, st, we, jp, cb, ev, sel;
    ld = (kind == K_LOAD);
    st = (kind == K_STORE);
    we = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JAL);
    jp = (kind == K_JAL);
    cb = (kind == K_BR);
    ev = (kind == K_ENV);
    sel = jp | (cb & taken);

    for (int k = 0; k < iw; k++) begin
      rand_dec();
      imem_ready = 1'b0;
      dmem_ready = 1'($urandom);
      step(mk(3'd0, 8'b1000_0000));
    end
    rand_dec();
    imem_ready = 1'b1;
    step(mk(3'd0, 8'b1100_0000));

    is_load = ld; is_store = st; wb_we = we; jump = jp;
    cond_br = cb; br_taken = taken; env = ev;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    step(mk(3'd1, 8'b0));

    if (ev) begin
      for (int k = 0; k < 20; k++) begin
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        step(mk(3'd7, 8'b0000_0001));
      end
      rst = 1'b1;
      step(mk(3'd7, 8'b0000_0001));
      rst = 1'b0;
      model_cnt = 0;
      return;
    end

    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    step(mk(3'd2, 8'b0));

    if (ld || st) begin
      for (int k = 0; k < dw; k++) begin
        dmem_ready = 1'b0;
        imem_ready = 1'($urandom);
        step(mk(3'd3, {2'b00, 1'b1, st, 4'b0}));
      end
      if (rst_in_mem) begin
        rst = 1'b1;
        dmem_ready = 1'($urandom);
        step(mk(3'd3, 8'b0));
        rst = 1'b0;
        model_cnt = 0;
        return;
      end
      dmem_ready = 1'b1;
      step(mk(3'd3, {2'b00, 1'b1, st, 4'b0}));
    end

    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    step(mk(3'd4, {4'b0, we, 1'b1, sel, 1'b0}));
    model_cnt = (model_cnt + 1) % 16;
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, halted, instret};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle %0d outputs st/imr/irw/dmr/dmw/rfw/pcw/pcs/hlt/cnt: got %0d/%b%b%b%b%b%b%b%b/%0d want %0d/%b%b%b%b%b%b%b%b/%0d",
                 cyc, a[14:12], a[11], a[10], a[9], a[8], a[7], a[6], a[5], a[4], a[3:0],
                 e[14:12], e[11], e[10], e[9], e[8], e[7], e[6], e[5], e[4], e[3:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rand_dec();
    @(posedge clk);
    #1;
    step(mk(3'd0, 8'b0));
    rst = 1'b0;

    run_instr(K_ALU, 0, 0, 1'b0, 1'b0);
    run_instr(K_ALU, 3, 0, 1'b0, 1'b0);
    run_instr(K_STORE, 0, 2, 1'b0, 1'b0);
    run_instr(K_BR, 0, 0, 1'b0, 1'b1);
    run_instr(K_BR, 0, 0, 1'b0, 1'b0);
    run_instr(K_JAL, 0, 0, 1'b0, 1'b0);
    run_instr(K_LOAD, 1, 0, 1'b0, 1'b0);
    run_instr(K_ENV, 0, 0, 1'b0, 1'b0);
    run_instr(K_LOAD, 0, 1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++)
      run_instr(K_ALU, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = ($urandom_range(0, 24) == 0) ? K_ENV : int'($urandom_range(0, 4));
      run_instr(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0), 1'($urandom));
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
